// File: rtl/mini_alu_pkg.sv
// Shared opcode encoding and instruction-field layout for the mini ALU core.
// Instruction word: {opcode, dst, src1, src0}, each register field ADDR_W wide.
package mini_alu_pkg;

    localparam int OPC_W      = 4;
    localparam int NUM_FIELDS = 3;
    localparam int DST_IDX    = 2;
    localparam int SRC1_IDX   = 1;
    localparam int SRC0_IDX   = 0;

    typedef enum logic [OPC_W-1:0] {
        OP_NOP = 4'd0,
        OP_LED = 4'd1,
        OP_BLE = 4'd2,
        OP_STO = 4'd3,
        OP_ADD = 4'd4,
        OP_JMP = 4'd5,
        OP_SUB = 4'd6,
        OP_OUT = 4'd7,
        OP_MUL = 4'd8,
        OP_SHL = 4'd9,
        OP_SHR = 4'd10
    } opcode_e;

    function automatic int instr_w(input int addr_w);
        return OPC_W + NUM_FIELDS * addr_w;
    endfunction

    function automatic int field_lsb(input int idx, input int addr_w);
        return idx * addr_w;
    endfunction

endpackage

// File: rtl/mini_alu_stall_core_if.sv
// Register-file access bundle: two read ports and one write port.
interface mini_alu_stall_core_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] raddr0;
    logic [ADDR_W-1:0] raddr1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;

    modport master (output raddr0, raddr1, we, waddr, wdata, input rdata0, rdata1);
    modport slave  (input raddr0, raddr1, we, waddr, wdata, output rdata0, rdata1);
endinterface

// File: rtl/mini_alu_stall_core_regfile.sv
// 2-read / 1-write register file; reads are combinational, the write lands on
// the clock edge, and reset clears every entry asynchronously.
module regfile_2r1w #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    mini_alu_stall_core_if.slave  rf
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (rf.we) begin
            mem[rf.waddr] <= rf.wdata;
        end
    end

    assign rf.rdata0 = mem[rf.raddr0];
    assign rf.rdata1 = mem[rf.raddr1];

endmodule

// File: rtl/mini_alu_stall_core.sv
// Two-stage (fetch / execute) mini ALU core with a stalling byte-output port.
// Taken branches squash the slot fetched alongside them (1-cycle penalty).
module mini_alu_stall_core
    import mini_alu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int IP_W   = 16,
    parameter int LED_W  = 8
) (
    input  logic                        Clock,
    input  logic                        Reset,
    output logic [IP_W-1:0]             oIAddr,
    input  logic [instr_w(ADDR_W)-1:0]  iInstr,
    output logic [LED_W-1:0]            oLed,
    output logic                        oDevValid,
    output logic [7:0]                  oDevData,
    input  logic                        iDevReady,
    output logic                        oIllegal
);
    localparam int INSTR_W = instr_w(ADDR_W);
    localparam int SHAMT_W = $clog2(DATA_W);

    logic [IP_W-1:0]   ip_p0;
    logic [OPC_W-1:0]  opc_p1;
    logic [ADDR_W-1:0] dst_p1;
    logic [ADDR_W-1:0] src1_p1;
    logic [ADDR_W-1:0] src0_p1;
    logic [DATA_W-1:0] a_p1;
    logic [DATA_W-1:0] b_p1;
    logic [DATA_W-1:0] wr_data;
    logic              wr_en;
    logic              taken;
    logic              stall;

    function automatic logic [DATA_W-1:0] alu(input logic [OPC_W-1:0]  opc,
                                              input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] r;
        r = '0;
        case (opc)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_MUL:  r = a * b;
            OP_SHL:  r = a << b[SHAMT_W-1:0];
            OP_SHR:  r = a >> b[SHAMT_W-1:0];
            default: r = '0;
        endcase
        return r;
    endfunction

    mini_alu_stall_core_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) rf_bus ();

    regfile_2r1w #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rf (
        .clk (Clock),
        .rst (Reset),
        .rf  (rf_bus.slave)
    );

    // ---- execute stage (p1): operand read, ALU, branch resolve ----
    assign rf_bus.raddr1 = src1_p1;
    assign rf_bus.raddr0 = src0_p1;
    assign a_p1          = rf_bus.rdata1;
    assign b_p1          = rf_bus.rdata0;

    always_comb begin
        wr_en   = 1'b0;
        wr_data = alu(opc_p1, a_p1, b_p1);
        taken   = 1'b0;
        case (opc_p1)
            OP_ADD, OP_SUB, OP_MUL, OP_SHL, OP_SHR: wr_en = 1'b1;
            OP_STO: begin
                wr_en   = 1'b1;
                wr_data = DATA_W'({src1_p1, src0_p1});
            end
            OP_BLE:  taken = (a_p1 <= b_p1);
            OP_JMP:  taken = 1'b1;
            default: ;
        endcase
    end

    // OUT is the only opcode that can hold the pipeline
    assign stall     = (opc_p1 == OP_OUT) && !iDevReady;
    assign oDevValid = (opc_p1 == OP_OUT);
    assign oDevData  = a_p1[7:0];
    assign oIllegal  = (opc_p1 > OP_SHR);

    assign rf_bus.we    = wr_en && !stall;
    assign rf_bus.waddr = dst_p1;
    assign rf_bus.wdata = wr_data;

    assign oIAddr = ip_p0;

    // ---- fetch (p0) -> execute (p1) boundary ----
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            ip_p0   <= '0;
            opc_p1  <= OP_NOP;
            dst_p1  <= '0;
            src1_p1 <= '0;
            src0_p1 <= '0;
            oLed    <= '0;
        end else if (!stall) begin
            ip_p0 <= taken ? IP_W'(dst_p1) : ip_p0 + IP_W'(1);
            if (taken) begin
                opc_p1  <= OP_NOP;
                dst_p1  <= '0;
                src1_p1 <= '0;
                src0_p1 <= '0;
            end else begin
                opc_p1  <= iInstr[INSTR_W-1 -: OPC_W];
                dst_p1  <= iInstr[field_lsb(DST_IDX, ADDR_W)  +: ADDR_W];
                src1_p1 <= iInstr[field_lsb(SRC1_IDX, ADDR_W) +: ADDR_W];
                src0_p1 <= iInstr[field_lsb(SRC0_IDX, ADDR_W) +: ADDR_W];
            end
            if (opc_p1 == OP_LED) begin
                oLed <= a_p1[LED_W-1:0];
            end
        end
    end

endmodule

// File: doc/mini_alu_stall_core.md
MINI_ALU_STALL_CORE -- requirements
Module: mini_alu_stall_core

Interface
REQ-001 SHALL have parameter DATA_W, default 16: datapath and register width.
REQ-002 SHALL have parameter ADDR_W, default 8: register-file address width; depth = 2**ADDR_W.
REQ-003 SHALL have parameter IP_W, default 16: instruction-pointer width.
REQ-004 SHALL have parameter LED_W, default 8: LED output width (LED_W <= DATA_W).
REQ-005 SHALL have port Clock, input, 1: sole clock, rising edge.
REQ-006 SHALL have port Reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port oIAddr, output, IP_W: instruction-memory address, equal to the IP register.
REQ-008 SHALL have port iInstr, input, 4+3*ADDR_W: instruction word, combinational from oIAddr; fields are [top 4] opcode, then dst, src1, src0.
REQ-009 SHALL have port oLed, output, LED_W: registered LED value.
REQ-010 SHALL have port oDevValid, output, 1: output-device transfer request.
REQ-011 SHALL have port oDevData, output, 8: output-device byte.
REQ-012 SHALL have port iDevReady, input, 1: output-device accept.
REQ-013 SHALL have port oIllegal, output, 1: one-cycle pulse when an undefined opcode executes.

Function
REQ-014 SHALL be a two-stage pipeline: fetch (IP, iInstr) and execute (latched opcode/dst/src1/src0); the register file is read combinationally in execute and written at the end of execute.
REQ-015 SHALL, each non-stalled cycle, latch iInstr into execute and set IP to IP+1, wrapping modulo 2**IP_W.
REQ-016 SHALL need no forwarding: a write from instruction N SHALL be visible to instruction N+1.
REQ-017 SHALL decode opcodes: NOP=0, LED=1, BLE=2, STO=3, ADD=4, JMP=5, SUB=6, OUT=7, MUL=8, SHL=9, SHR=10; 11-15 are illegal.
REQ-018 SHALL define, with A=R[src1] and B=R[src0]: ADD R[dst]=A+B; SUB R[dst]=A-B; MUL R[dst]=low DATA_W bits of A*B; SHL/SHR R[dst]=A shifted logically by B[log2(DATA_W)-1:0]. All results wrap modulo 2**DATA_W.
REQ-019 SHALL, for STO, write R[dst] with the immediate {src1,src0}, zero-extended to DATA_W or truncated to its low DATA_W bits.
REQ-020 SHALL, for LED, load oLed with A[LED_W-1:0] at the end of the execute cycle.
REQ-021 SHALL take BLE when A <= B (unsigned), and take JMP always.
REQ-022 SHALL, for a taken branch, load IP with dst zero-extended to IP_W and replace the instruction fetched in that cycle with NOP. Penalty: exactly 1 cycle.
REQ-023 SHALL, for OUT, drive oDevValid=1 and oDevData=A[7:0] combinationally from execute state.
REQ-024 SHALL, when oDevValid=1 and iDevReady=0, stall: IP, execute register, register file and oLed hold. The transfer completes on the first edge with iDevReady=1.
REQ-025 SHALL keep oDevData stable while oDevValid=1, and hold oDevValid=0 for every opcode other than OUT.
REQ-026 SHALL treat an illegal opcode as NOP and pulse oIllegal for that execute cycle.
REQ-027 SHALL never write the register file or oLed in the cycle a NOP or squashed slot executes.

Reset
REQ-028 SHALL, while Reset=1, immediately force IP=0, execute register=NOP, oLed=0, all register-file entries=0, oDevValid=0 and oIllegal=0.
REQ-029 SHALL, when Reset asserts during an OUT stall, drop oDevValid at once; the transfer is not completed.
REQ-030 SHALL, on the first edge after Reset deasserts, latch instruction 0 into execute.

Structure
REQ-031 SHALL place the opcode constants and the instruction-field width/position constants in shared package mini_alu_pkg.
REQ-032 SHALL implement the register file as sub-module regfile_2r1w: 2 combinational reads, 1 synchronous write, asynchronous clear.

Verification
REQ-033 SHALL cover ALU ops: STO R1,5; STO R2,3; SUB R3,R1,R2; MUL R4,R1,R2; SHL R5,R1,R2 -> R3=2, R4=15, R5=40.
REQ-034 SHALL cover wrap-around: STO R1,0xFFFF; STO R2,1; ADD R3,R1,R2; LED R3 -> R3=0, oLed=0x00.
REQ-035 SHALL cover branch squash: BLE to 0x10 with A=2, B=7 at address 4 -> next executed address is 0x10; the instruction at 5 never writes.
REQ-036 SHALL cover the OUT stall: OUT R1 (R1=0x41) with iDevReady low for 3 cycles -> oDevValid=1 and oDevData=0x41 for 4 cycles; IP frozen; advance follows the accept edge.
REQ-037 SHALL cover reset mid-stall: Reset pulsed during a stalled OUT -> oDevValid=0 immediately; oIAddr=0; registers read 0.
REQ-038 SHALL cover illegal opcode: opcode 0xC -> single oIllegal pulse; no register or LED change; IP advances by 1.
